counter_sequencer: RTL and testbench

- Command-driven controller for the 8-bit prescaled counter.
- Accepts a (start, target) command over a valid/ready handshake, then loads the counter with start and enables it until count reaches target.
- Signals completion with a one-cycle done pulse and the final count.
- Has a watchdog timeout and an abort input. Sits between the system control logic and the counter's enable, write and load-value inputs.

---
 rtl/counter_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_counter_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Purpose: command-driven controller that loads the prescaled counter with start and enables it until count == target.
// Latency: handshake at edge N -> write pulse in N+1, RUN from N+2, earliest done_o in N+3 (one more cycle through the queue).
// Backpressure: cmd_ready_o low while a run is active; optional COUNTER_SEQUENCER_CMD_QUEUE_EN adds a 2-entry command queue.

`ifdef COUNTER_SEQUENCER_CMD_QUEUE_EN
// Generic register FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module counter_sequencer_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign push_rdy = (cnt != (AW+1)'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: entries are only read when marked valid.
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule
`endif

module counter_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_start_i,
  input  logic [WIDTH-1:0] cmd_target_i,
  input  logic             abort_i,
  output logic             ctr_enable_o,
  output logic             ctr_write_o,
  output logic [WIDTH-1:0] ctr_val_o,
  input  logic [WIDTH-1:0] ctr_count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int            WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, target_q, result_q;
  logic [WD_W-1:0]  wdog_q;
  logic             tmo_q, tmo_d;
  logic             cmd_take;
  logic             cmd_src_vld;
  logic [WIDTH-1:0] cmd_src_start, cmd_src_target;
  logic             match;

`ifdef COUNTER_SEQUENCER_CMD_QUEUE_EN
  logic               q_push_rdy;
  logic               q_pop_vld;
  logic [2*WIDTH-1:0] q_pop_dat;

  counter_sequencer_fifo #(.W(2*WIDTH), .DEPTH(2)) u_cmd_fifo (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .push_vld (cmd_valid_i),
    .push_dat ({cmd_start_i, cmd_target_i}),
    .push_rdy (q_push_rdy),
    .pop_vld  (q_pop_vld),
    .pop_dat  (q_pop_dat),
    .pop_rdy  (cmd_take)
  );

  assign cmd_src_vld                     = q_pop_vld;
  assign {cmd_src_start, cmd_src_target} = q_pop_dat;
  assign cmd_ready_o                     = q_push_rdy;
  assign busy_o                          = (state_q != ST_IDLE) || q_pop_vld;
`else
  assign cmd_src_vld    = cmd_valid_i;
  assign cmd_src_start  = cmd_start_i;
  assign cmd_src_target = cmd_target_i;
  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
`endif

  assign match = (ctr_count_i == target_q);

  // Counter enable stops on the match itself, so the counter never passes target.
  assign ctr_enable_o = (state_q == ST_RUN) && !match && !abort_i;
  assign ctr_write_o  = (state_q == ST_LOAD);
  assign ctr_val_o    = start_q;
  assign done_o       = (state_q == ST_DONE);
  assign timeout_o    = (state_q == ST_DONE) && tmo_q;
  assign result_o     = result_q;

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; RUN exit priority is abort, then match, then watchdog.
  always_comb begin
    state_d  = state_q;
    cmd_take = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_src_vld) begin
          cmd_take = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (match) begin
          state_d = ST_DONE;
          tmo_d   = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef COUNTER_SEQUENCER_CMD_QUEUE_EN
        if (cmd_src_vld) begin
          cmd_take = 1'b1;
          state_d  = ST_LOAD;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, watchdog, timeout flag and result capture.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      start_q  <= '0;
      target_q <= '0;
      wdog_q   <= '0;
      tmo_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (cmd_take) begin
        start_q  <= cmd_src_start;
        target_q <= cmd_src_target;
      end
      if (state_q == ST_LOAD)     wdog_q <= '0;
      else if (state_q == ST_RUN) wdog_q <= wdog_q + 1'b1;
      tmo_q <= tmo_d;
      if (state_q == ST_DONE) result_q <= ctr_count_i;
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// Purpose: directed bench for counter_sequencer with a simple counter model behind it.
// Latency: cycles are counted from the negedge after the handshake edge (1 = LOAD).
// Backpressure: command hold-off while busy is exercised with cmd_valid_i held high.
module tb_counter_sequencer;
  logic       clock_i;
  logic       reset_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_start_i;
  logic [7:0] cmd_target_i;
  logic       abort_i;
  logic       ctr_enable_o;
  logic       ctr_write_o;
  logic [7:0] ctr_val_o;
  logic [7:0] ctr_count_i;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic [7:0] result_o;

  logic       hold;
  int         n_chk = 0;
  int         n_bad = 0;

  counter_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_start_i  (cmd_start_i),
    .cmd_target_i (cmd_target_i),
    .abort_i      (abort_i),
    .ctr_enable_o (ctr_enable_o),
    .ctr_write_o  (ctr_write_o),
    .ctr_val_o    (ctr_val_o),
    .ctr_count_i  (ctr_count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .result_o     (result_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Counter model: load on write, step on enable, forced to zero while hold is set.
  always @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)         ctr_count_i <= 8'h00;
    else if (hold)        ctr_count_i <= 8'h00;
    else if (ctr_write_o) ctr_count_i <= ctr_val_o;
    else if (ctr_enable_o) ctr_count_i <= ctr_count_i + 8'h01;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full command; called at a negedge with the DUT idle.
  task automatic run_and_check(input string name, input logic [7:0] s, input logic [7:0] t,
                               input int exp_done, input int exp_en, input logic exp_tmo,
                               input logic [7:0] exp_res);
    int         wr, en, dc;
    logic       tm;
    logic [7:0] wv;
    cmd_valid_i  = 1'b1;
    cmd_start_i  = s;
    cmd_target_i = t;
    #1;
    chk({name, "_ready"}, cmd_ready_o, 1);
    @(posedge clock_i);
    @(negedge clock_i);
    cmd_valid_i = 1'b0;
    wr = 0; en = 0; dc = -1; tm = 1'b0; wv = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      if (ctr_write_o) begin wr++; wv = ctr_val_o; end
      if (ctr_enable_o) en++;
      if (done_o) begin dc = c; tm = timeout_o; break; end
      @(negedge clock_i);
    end
    chk({name, "_done_cycle"}, dc, exp_done);
    chk({name, "_enable_cycles"}, en, exp_en);
    chk({name, "_write_pulses"}, wr, 1);
    chk({name, "_write_val"}, wv, s);
    chk({name, "_timeout"}, tm, exp_tmo);
    @(negedge clock_i);
    chk({name, "_result"}, result_o, exp_res);
    chk({name, "_done_low"}, {done_o, timeout_o, busy_o}, 0);
  endtask

  initial begin
    int acc, a_done, dc, seen;
    reset_i = 1'b0; cmd_valid_i = 1'b0; cmd_start_i = 8'h00; cmd_target_i = 8'h00;
    abort_i = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clock_i);
    chk("reset_ready", cmd_ready_o, 1);
    chk("reset_outs", {ctr_enable_o, ctr_write_o, busy_o, done_o, timeout_o}, 0);
    chk("reset_val", ctr_val_o, 0);
    chk("reset_result", result_o, 0);
    reset_i = 1'b1;
    @(negedge clock_i);

    run_and_check("basic",  8'h10, 8'h14, 7, 4, 1'b0, 8'h14);
    run_and_check("wrap",   8'hFE, 8'h01, 6, 3, 1'b0, 8'h01);
    run_and_check("equal",  8'h33, 8'h33, 3, 0, 1'b0, 8'h33);

    // Abort on the same cycle as the match.
    cmd_valid_i = 1'b1; cmd_start_i = 8'h20; cmd_target_i = 8'h22;
    @(posedge clock_i);
    @(negedge clock_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clock_i);
    abort_i = 1'b1;
    #1;
    chk("abort_enable", ctr_enable_o, 0);
    chk("abort_busy", busy_o, 1);
    @(posedge clock_i);
    @(negedge clock_i);
    abort_i = 1'b0;
    chk("abort_idle", {busy_o, cmd_ready_o, done_o}, 3'b010);
    chk("abort_result", result_o, 8'h33);
    seen = 0;
    repeat (3) begin @(negedge clock_i); if (done_o) seen++; end
    chk("abort_no_done", seen, 0);

    hold = 1'b1;
    run_and_check("timeout", 8'h00, 8'h05, 10, 8, 1'b1, 8'h00);
    hold = 1'b0;

    // Second command held off until the first run returns to IDLE.
    cmd_valid_i = 1'b1; cmd_start_i = 8'h01; cmd_target_i = 8'h02;
    @(posedge clock_i);
    @(negedge clock_i);
    cmd_start_i = 8'h05; cmd_target_i = 8'h05;
    acc = -1; a_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_o) a_done++;
      if (cmd_ready_o) begin acc = c; break; end
      @(negedge clock_i);
    end
    chk("b2b_accept_cycle", acc, 5);
    chk("b2b_first_done", a_done, 1);
    chk("b2b_first_result", result_o, 8'h02);
    @(posedge clock_i);
    @(negedge clock_i);
    cmd_valid_i = 1'b0;
    dc = -1;
    for (int c = 6; c <= 30; c++) begin
      if (done_o) begin dc = c; break; end
      @(negedge clock_i);
    end
    chk("b2b_second_done", dc, 8);
    @(negedge clock_i);
    chk("b2b_second_result", result_o, 8'h05);

    // Asynchronous reset in the middle of a run.
    cmd_valid_i = 1'b1; cmd_start_i = 8'h40; cmd_target_i = 8'h50;
    @(posedge clock_i);
    @(negedge clock_i);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clock_i);
    chk("rst_pre_enable", ctr_enable_o, 1);
    #2 reset_i = 1'b0;
    #1;
    chk("rst_outs", {ctr_enable_o, ctr_write_o, busy_o, done_o, timeout_o}, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_val", ctr_val_o, 0);
    chk("rst_result", result_o, 0);
    #4 reset_i = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clock_i); if (done_o || busy_o) seen++; end
    chk("rst_cmd_lost", seen, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
